// File: rtl/fuzz_top.sv
// ============================================================================
//  fuzz_top : two-stage registered add / multiply / compare-XOR / accumulate
//             datapath packed into an 87-bit status word
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fuzz_top (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] wire0,
  input  logic [13:0] wire1,
  input  logic [20:0] wire2,
  input  logic [15:0] wire3,
  output logic [86:0] y
);

  logic [20:0] r0_q, r0_d;
  logic [13:0] r1_q, r1_d;
  logic [20:0] r2_q, r2_d;
  logic [15:0] r3_q, r3_d;

  logic [21:0] p_sum_q, p_sum_d;
  logic [30:0] p_mul_q, p_mul_d;
  logic [20:0] p_mix_q, p_mix_d;
  logic [12:0] acc_q,   acc_d;

  logic [30:0] w_mul_a;
  logic [30:0] w_mul_b;
  logic        w_lt;

  always_comb begin
    r0_d = wire0;
    r1_d = wire1;
    r2_d = wire2;
    r3_d = wire3;

    p_sum_d = {r0_q[20], r0_q} + {{6{r3_q[15]}}, r3_q};

    // Both operands widened to the product width; the low 31 bits of the
    // unsigned product equal the two's-complement signed product.
    w_mul_a = {{15{r3_q[15]}}, r3_q};
    w_mul_b = {17'b0, r1_q};
    p_mul_d = w_mul_a * w_mul_b;

    w_lt    = $signed(r0_q) < $signed({{5{r3_q[15]}}, r3_q});
    p_mix_d = w_lt ? r2_q : (r2_q ^ {7'b0, r1_q});

    acc_d   = acc_q + r1_q[12:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      p_sum_q <= '0;
      p_mul_q <= '0;
      p_mix_q <= '0;
      acc_q   <= '0;
    end else begin
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      p_sum_q <= p_sum_d;
      p_mul_q <= p_mul_d;
      p_mix_q <= p_mix_d;
      acc_q   <= acc_d;
    end
  end

  assign y = {acc_q, p_mul_q, p_mix_q, p_sum_q};

endmodule

`default_nettype wire

// File: tb/tb_fuzz_top.sv
// ============================================================================
//  tb_fuzz_top : vector table, corner sequences and random run for fuzz_top
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fuzz_top;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] wire0 = '0;
  logic [13:0] wire1 = '0;
  logic [20:0] wire2 = '0;
  logic [15:0] wire3 = '0;
  logic [86:0] y;

  fuzz_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wire0 (wire0),
    .wire1 (wire1),
    .wire2 (wire2),
    .wire3 (wire3),
    .y     (y)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [20:0] w0;
    logic [13:0] w1;
    logic [20:0] w2;
    logic [15:0] w3;
  } in_t;

  typedef struct {
    logic [20:0] w0;
    logic [13:0] w1;
    logic [20:0] w2;
    logic [15:0] w3;
    logic [21:0] e_sum;
    logic [30:0] e_mul;
    logic [20:0] e_mix;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  in_t         stage_m;
  int          acc_m;
  logic [86:0] y_m;

  function automatic logic [86:0] ref_y(in_t s, int acc_v);
    longint a, d, b, c, sum, mul, mix;
    a = longint'(s.w0);
    if (s.w0[20]) a = a - 64'sd2097152;
    d = longint'(s.w3);
    if (s.w3[15]) d = d - 64'sd65536;
    b   = longint'(s.w1);
    c   = longint'(s.w2);
    sum = a + d;
    mul = d * b;
    mix = (a < d) ? c : (c ^ b);
    return {13'(acc_v), 31'(mul), 21'(mix), 22'(sum)};
  endfunction

  task automatic check(input string name, input logic [86:0] got, input logic [86:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    stage_m = '0;
    acc_m   = 0;
    y_m     = '0;
  endtask

  // One clock: the model advances at the edge, the DUT is sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      acc_m   = (acc_m + int'(stage_m.w1[12:0])) % 8192;
      y_m     = ref_y(stage_m, acc_m);
      stage_m = {wire0, wire1, wire2, wire3};
    end else begin
      model_reset();
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic [20:0] a, input logic [13:0] b,
                        input logic [20:0] c, input logic [15:0] d);
    wire0 = a;
    wire1 = b;
    wire2 = c;
    wire3 = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [12:0] wrap_exp[4];
    logic [12:0] acc_base;

    vecs[0] = '{21'd5,       14'd2,      21'h10,     16'hFFFD, 22'h000002, 31'h7FFFFFFA, 21'h000012};
    vecs[1] = '{21'h100000,  14'd0,      21'h0ABCDE, 16'h8000, 22'h2F8000, 31'h00000000, 21'h0ABCDE};
    vecs[2] = '{21'd0,       14'h3FFF,   21'd0,      16'h8000, 22'h3F8000, 31'h60008000, 21'h003FFF};
    vecs[3] = '{21'd0,       14'd0,      21'd0,      16'h8000, 22'h3F8000, 31'h00000000, 21'h000000};
    vecs[4] = '{21'd7,       14'h0F0,    21'h1FFFFF, 16'd7,    22'h00000E, 31'h00000690, 21'h1FFF0F};
    vecs[5] = '{21'h0FFFFF,  14'h3FFF,   21'h155555, 16'h7FFF, 22'h107FFE, 31'h1FFF4001, 21'h156AAA};

    wrap_exp[0] = 13'h0000;
    wrap_exp[1] = 13'h1000;
    wrap_exp[2] = 13'h0000;
    wrap_exp[3] = 13'h1000;

    model_reset();

    // Reset holds y at zero regardless of inputs and clocking.
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_in(21'($urandom()), 14'($urandom()), 21'($urandom()), 16'($urandom()));
      tick();
      check("reset_y", y, 87'h0);
    end

    // Table of held operands, each checked after the two-edge latency.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
      tick();
      tick();
      check($sformatf("vec%0d_sum", i), 87'(y[21:0]),  87'(vecs[i].e_sum));
      check($sformatf("vec%0d_mix", i), 87'(y[42:22]), 87'(vecs[i].e_mix));
      check($sformatf("vec%0d_mul", i), 87'(y[73:43]), 87'(vecs[i].e_mul));
      check($sformatf("vec%0d_acc", i), 87'(y[86:74]), 87'(13'(acc_m)));
    end

    // Accumulator wrap from reset with 0x1000 held.
    rst_n = 1'b0;
    set_in(21'd0, 14'h1000, 21'd0, 16'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("wrap%0d", i), 87'(y[86:74]), 87'(wrap_exp[i]));
    end

    // Bit 13 of wire1 does not reach the accumulator.
    wire1 = 14'h2001;
    tick();
    check("acc_b13_model", y, y_m);
    acc_base = y[86:74];
    tick();
    check("acc_b13_step1", 87'(y[86:74]), 87'(13'(acc_base + 13'd1)));
    tick();
    check("acc_b13_step2", 87'(y[86:74]), 87'(13'(acc_base + 13'd2)));

    // Asynchronous reset asserted between edges.
    set_in(21'h012345, 14'h0123, 21'h0F0F0F, 16'h1234);
    tick();
    tick();
    check("pre_async_nonzero", 87'(y != 87'h0), 87'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", y, 87'h0);
    model_reset();
    tick();
    check("async_hold", y, 87'h0);
    rst_n = 1'b1;
    tick();
    check("refill_1", y, 87'h0);
    tick();
    check("refill_2", y, ref_y({21'h012345, 14'h0123, 21'h0F0F0F, 16'h1234}, 13'h0123));
    check("refill_2_model", y, y_m);

    // Random run, with corner operands mixed in and occasional held inputs.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 5))
          0:       set_in(21'h100000, 14'h3FFF, 21'($urandom()), 16'h8000);
          1:       set_in(21'h0FFFFF, 14'h3FFF, 21'($urandom()), 16'h7FFF);
          2: begin
            wire0 = 21'($urandom());
            wire3 = wire0[15:0];
            wire0 = {{5{wire3[15]}}, wire3};
            wire1 = 14'($urandom());
            wire2 = 21'($urandom());
          end
          default: set_in(21'($urandom()), 14'($urandom()), 21'($urandom()), 16'($urandom()));
        endcase
      end
      tick();
      check("random_y", y, y_m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
